// File: rtl/gcd_cpu_pkg.sv
// Shared types and constants for the GCD processor: FSM states, memory geometry and
// the fixed data-memory addresses used by the host and the sequencer.
package gcd_cpu_pkg;

  localparam int unsigned DM_DEPTH = 128;
  localparam int unsigned ADDR_W   = 7;

  localparam logic [ADDR_W-1:0] ADDR_A   = 7'd0;
  localparam logic [ADDR_W-1:0] ADDR_B   = 7'd1;
  localparam logic [ADDR_W-1:0] ADDR_RES = 7'd2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCompute,
    StStore
  } state_e;

endpackage

// File: rtl/gcd_cpu_if.sv
// Host-side bus of the GCD processor: operand load, run request, busy flag and
// the two combinational memory read paths.
interface gcd_cpu_if;

  logic [31:0] hdin1;
  logic [31:0] hdin2;
  logic        wen;
  logic        start;
  logic [31:0] haddr;
  logic        bsy;
  logic [31:0] dout;
  logic [31:0] gcd_answer;

  modport master (
    output hdin1,
    output hdin2,
    output wen,
    output start,
    output haddr,
    input  bsy,
    input  dout,
    input  gcd_answer
  );

  modport slave (
    input  hdin1,
    input  hdin2,
    input  wen,
    input  start,
    input  haddr,
    output bsy,
    output dout,
    output gcd_answer
  );

endinterface

// File: rtl/gcd_dmem.sv
// 128x32 data memory with synchronous clear, a host operand write path into words 0/1,
// a sequencer result write into word 2 and asynchronous reads.
module gcd_dmem
  import gcd_cpu_pkg::*;
(
  input  logic              CLK_1M,
  input  logic              rst,
  input  logic              host_we,
  input  logic [31:0]       host_wdata_a,
  input  logic [31:0]       host_wdata_b,
  input  logic              res_we,
  input  logic [31:0]       res_wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  output logic [31:0]       res_rdata,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b
);

  logic [31:0] mem_q [DM_DEPTH];

  // host_we and res_we are never high together: one is IDLE-only, the other STORE-only.
  always_ff @(posedge CLK_1M) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      if (host_we) begin
        mem_q[ADDR_A] <= host_wdata_a;
        mem_q[ADDR_B] <= host_wdata_b;
      end
      if (res_we) begin
        mem_q[ADDR_RES] <= res_wdata;
      end
    end
  end

  assign rdata     = mem_q[raddr];
  assign res_rdata = mem_q[ADDR_RES];
  assign op_a      = mem_q[ADDR_A];
  assign op_b      = mem_q[ADDR_B];

endmodule

// File: rtl/gcd_cpu.sv
// Sequenced subtractive-Euclid GCD engine: loads operands from DM[0]/DM[1], iterates one
// compare/subtract per cycle and writes the result to DM[2].
module gcd_cpu
  import gcd_cpu_pkg::*;
(
  input  logic      CLK_1M,
  input  logic      rst,
  gcd_cpu_if.slave  bus
);

  state_e      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;
  logic        bsy_q;
  logic        res_we_q;

  logic        host_we;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] rdata;
  logic [31:0] res_rdata;

  // Host writes land on the same edge that leaves IDLE, so LOAD sees fresh operands.
  assign host_we = bus.wen && (state_q == StIdle);

  gcd_dmem u_dmem (
    .CLK_1M       (CLK_1M),
    .rst          (rst),
    .host_we      (host_we),
    .host_wdata_a (bus.hdin1),
    .host_wdata_b (bus.hdin2),
    .res_we       (res_we_q),
    .res_wdata    (result_q),
    .raddr        (bus.haddr[ADDR_W-1:0]),
    .rdata        (rdata),
    .res_rdata    (res_rdata),
    .op_a         (op_a),
    .op_b         (op_b)
  );

  always_ff @(posedge CLK_1M) begin
    if (rst) begin
      state_q  <= StIdle;
      bsy_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      res_we_q <= 1'b0;
    end else begin
      res_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StLoad;
            bsy_q   <= 1'b1;
          end
        end
        StLoad: begin
          a_q     <= op_a;
          b_q     <= op_b;
          state_q <= StCompute;
        end
        StCompute: begin
          if (b_q == '0) begin
            result_q <= a_q;
            res_we_q <= 1'b1;
            state_q  <= StStore;
          end else if (a_q == '0) begin
            result_q <= b_q;
            res_we_q <= 1'b1;
            state_q  <= StStore;
          end else if (a_q == b_q) begin
            result_q <= a_q;
            res_we_q <= 1'b1;
            state_q  <= StStore;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        StStore: begin
          state_q <= StIdle;
          bsy_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bsy        = bsy_q;
  assign bus.dout       = rdata;
  assign bus.gcd_answer = res_rdata;

endmodule

// File: tb/tb_gcd_cpu.sv
// Directed and randomized bench for gcd_cpu, checked against a modulo-Euclid reference
// model for both the result and the length of the busy window.
module tb_gcd_cpu;

  localparam int unsigned BusyLimit = 5000;

  logic clk;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  gcd_cpu_if bus ();

  gcd_cpu u_dut (
    .CLK_1M (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a;
    logic [31:0] y = b;
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Subtractions done by subtractive Euclid, derived from quotients; the last quotient
  // contributes one less because the loop ends on equality rather than on zero.
  function automatic int unsigned sub_steps(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a;
    logic [31:0] y = b;
    int unsigned n = 0;
    while (x != 0 && y != 0) begin
      if (x >= y) begin
        if (x % y == 0) begin
          n += x / y - 1;
          break;
        end
        n += x / y;
        x = x % y;
      end else begin
        if (y % x == 0) begin
          n += y / x - 1;
          break;
        end
        n += y / x;
        y = y % x;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int unsigned cnt);
    cnt = 0;
    while (bus.bsy === 1'b1 && cnt < BusyLimit) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r);
    bus.haddr = 32'd0;
    #1 check({tag, "_dm0"}, bus.dout, a);
    bus.haddr = 32'd1;
    #1 check({tag, "_dm1"}, bus.dout, b);
    bus.haddr = 32'd2;
    #1 check({tag, "_dm2"}, bus.dout, r);
    check({tag, "_ans"}, bus.gcd_answer, r);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 128; i++) begin
      bus.haddr = 32'(i);
      #1 check($sformatf("%s_z%0d", tag, i), bus.dout, 32'd0);
    end
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input bit split,
                         input string tag);
    int unsigned cnt;
    @(negedge clk);
    bus.hdin1 = a;
    bus.hdin2 = b;
    bus.wen   = 1'b1;
    bus.start = !split;
    if (split) begin
      @(negedge clk);
      bus.wen   = 1'b0;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.wen   = 1'b0;
    bus.start = 1'b0;
    wait_idle(cnt);
    check({tag, "_cyc"}, cnt, sub_steps(a, b) + 3);
    check_mem(tag, a, b, gcd_ref(a, b));
  endtask

  initial begin
    int unsigned cnt;
    logic [31:0] g;
    logic [31:0] ra;
    logic [31:0] rb;

    rst       = 1'b1;
    bus.hdin1 = '0;
    bus.hdin2 = '0;
    bus.wen   = 1'b0;
    bus.start = 1'b0;
    bus.haddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_bsy", 32'(bus.bsy), 32'd0);
    check("rst_ans", bus.gcd_answer, 32'd0);
    check_all_zero("rst");

    run_job(32'd15, 32'd85, 1'b0, "t15_85");
    check("t15_85_cyc_lit", 32'(sub_steps(32'd15, 32'd85) + 3), 32'd10);
    run_job(32'd0, 32'd9, 1'b1, "t0_9");
    run_job(32'd12, 32'd0, 1'b0, "t12_0");
    run_job(32'd0, 32'd0, 1'b1, "t0_0");
    run_job(32'd7, 32'd7, 1'b0, "t7_7");
    run_job(32'd1, 32'd1000, 1'b1, "t1_1000");

    // Upper haddr bits are ignored: 0x...82 aliases word 2.
    bus.haddr = 32'hFFFF_FF82;
    #1 check("haddr_alias", bus.dout, 32'd1);
    bus.haddr = 32'd3;
    #1 check("dm3_untouched", bus.dout, 32'd0);

    // wen/start pulses while busy must be ignored.
    @(negedge clk);
    bus.hdin1 = 32'd15;
    bus.hdin2 = 32'd85;
    bus.wen   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.wen   = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    bus.hdin1 = 32'd99;
    bus.hdin2 = 32'd77;
    bus.wen   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.wen   = 1'b0;
    bus.start = 1'b0;
    wait_idle(cnt);
    check("ign_cyc", cnt + 2, 32'd10);
    check_mem("ign", 32'd15, 32'd85, 32'd5);
    @(negedge clk);
    check("ign_no_rerun", 32'(bus.bsy), 32'd0);

    // Reset in the third busy cycle aborts the run and clears memory.
    @(negedge clk);
    bus.hdin1 = 32'd15;
    bus.hdin2 = 32'd85;
    bus.wen   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.wen   = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_bsy", 32'(bus.bsy), 32'd0);
    check("midrst_ans", bus.gcd_answer, 32'd0);
    check_all_zero("midrst");
    run_job(32'd48, 32'd18, 1'b0, "t48_18");
    check("t48_18_lit", gcd_ref(32'd48, 32'd18), 32'd6);

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        ra = 32'($urandom_range(0, 3000));
        rb = 32'($urandom_range(0, 3000));
      end else begin
        g  = 32'($urandom_range(1, 1 << 20));
        ra = g * 32'($urandom_range(1, 200));
        rb = g * 32'($urandom_range(1, 200));
      end
      run_job(ra, rb, i[0] == 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
